music_note_sequencer: RTL and testbench

- Controller that steps a small programmable note table and drives a downstream tone generator, one note at a time.
- Each note has a period and a duration; notes are separated by a fixed silent gap.
- Supports start/stop, one-shot or looping playback, and a `done` pulse.
- Sits between the user/test control logic and the tone-generator datapath in the music lab. Its state and table are built from reset-able flip-flop registers.

---
 rtl/music_pkg.sv | 30 +++
 rtl/music_note_table.sv | 63 ++++++
 rtl/music_note_sequencer.sv | 173 +++++++++++++++++
 tb/tb_music_note_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// ============================================================================
//  Module      : music_pkg
//  Description : Shared types and default sizing for the note sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package music_pkg;

    localparam int NUM_NOTES_DEF = 8;
    localparam int PERIOD_W_DEF  = 8;
    localparam int DUR_W_DEF     = 4;
    localparam int TICK_DIV_DEF  = 4;
    localparam int GAP_CYC_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [PERIOD_W_DEF-1:0] period;
        logic [DUR_W_DEF-1:0]    dur;
    } note_entry_t;

endpackage

`default_nettype wire

// File: rtl/music_note_table.sv
// ============================================================================
//  Module      : music_note_table
//  Description : Note register file; sync write port, combinational read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module music_note_table
    import music_pkg::*;
#(
    parameter int NUM_NOTES = NUM_NOTES_DEF,
    parameter int PERIOD_W  = PERIOD_W_DEF,
    parameter int DUR_W     = DUR_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_NOTES)-1:0] wr_addr,
    input  logic [PERIOD_W-1:0]          wr_period,
    input  logic [DUR_W-1:0]             wr_dur,
    input  logic [$clog2(NUM_NOTES)-1:0] rd_addr,
    output logic [PERIOD_W-1:0]          rd_period,
    output logic [DUR_W-1:0]             rd_dur
);

    localparam int IDX_W = $clog2(NUM_NOTES);

    logic [NUM_NOTES-1:0][PERIOD_W-1:0] period_all;
    logic [NUM_NOTES-1:0][DUR_W-1:0]    dur_all;

    for (genvar i = 0; i < NUM_NOTES; i++) begin : g_entry
        logic [PERIOD_W-1:0] period_q, period_d;
        logic [DUR_W-1:0]    dur_q, dur_d;

        always_comb begin
            period_d = period_q;
            dur_d    = dur_q;
            if (wr_en && (wr_addr == IDX_W'(i))) begin
                period_d = wr_period;
                dur_d    = wr_dur;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                period_q <= '0;
                dur_q    <= '0;
            end else begin
                period_q <= period_d;
                dur_q    <= dur_d;
            end
        end

        assign period_all[i] = period_q;
        assign dur_all[i]    = dur_q;
    end

    assign rd_period = period_all[rd_addr];
    assign rd_dur    = dur_all[rd_addr];

endmodule

`default_nettype wire

// File: rtl/music_note_sequencer.sv
// ============================================================================
//  Module      : music_note_sequencer
//  Description : Steps the note table and drives a tone generator one note
//                at a time, with a silent gap between notes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module music_note_sequencer
    import music_pkg::*;
#(
    parameter int NUM_NOTES = NUM_NOTES_DEF,
    parameter int PERIOD_W  = PERIOD_W_DEF,
    parameter int DUR_W     = DUR_W_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop,
    input  logic [$clog2(NUM_NOTES):0]   len,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_NOTES)-1:0] wr_addr,
    input  logic [PERIOD_W-1:0]          wr_period,
    input  logic [DUR_W-1:0]             wr_dur,
    output logic [PERIOD_W-1:0]          note_period,
    output logic                         note_valid,
    output logic [$clog2(NUM_NOTES)-1:0] note_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int IDX_W = $clog2(NUM_NOTES);
    localparam int LEN_W = IDX_W + 1;
    localparam int CNT_W = $clog2((2**DUR_W) * TICK_DIV) + 1;

    state_t              state_q, state_d;
    logic                loop_q, loop_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [PERIOD_W-1:0] rd_period;
    logic [DUR_W-1:0]    rd_dur;
    logic [LEN_W-1:0]    len_clamped;
    logic [CNT_W-1:0]    play_last;
    logic [CNT_W-1:0]    gap_last;
    logic                last_note;

    // Read address follows the next index so the entry is latched on the PLAY-entry edge
    music_note_table #(
        .NUM_NOTES (NUM_NOTES),
        .PERIOD_W  (PERIOD_W),
        .DUR_W     (DUR_W)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_period (wr_period),
        .wr_dur    (wr_dur),
        .rd_addr   (idx_d),
        .rd_period (rd_period),
        .rd_dur    (rd_dur)
    );

    always_comb begin
        len_clamped = (len > LEN_W'(NUM_NOTES)) ? LEN_W'(NUM_NOTES) : len;
        play_last   = CNT_W'(((dur_q == '0) ? 1 : int'(dur_q)) * TICK_DIV - 1);
        gap_last    = CNT_W'(GAP_CYC - 1);
        last_note   = (LEN_W'(idx_q) + LEN_W'(1)) >= len_q;
    end

    always_comb begin
        state_d  = state_q;
        loop_d   = loop_q;
        len_d    = len_q;
        idx_d    = idx_q;
        period_d = period_q;
        dur_d    = dur_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    loop_d = loop;
                    len_d  = len_clamped;
                    idx_d  = '0;
                    cnt_d  = '0;
                    if (len_clamped == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_PLAY;
                        period_d = rd_period;
                        dur_d    = rd_dur;
                    end
                end
            end
            ST_PLAY: begin
                if (cnt_q == play_last) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == gap_last) begin
                    cnt_d = '0;
                    if (!last_note || loop_q) begin
                        idx_d    = last_note ? '0 : idx_q + IDX_W'(1);
                        state_d  = ST_PLAY;
                        period_d = rd_period;
                        dur_d    = rd_dur;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over every transition above and keeps the index for display
        if (stop && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            idx_d    = idx_q;
            period_d = period_q;
            dur_d    = dur_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            loop_q   <= 1'b0;
            len_q    <= '0;
            idx_q    <= '0;
            period_q <= '0;
            dur_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            loop_q   <= loop_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            period_q <= period_d;
            dur_q    <= dur_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign note_valid  = (state_q == ST_PLAY) && (period_q != '0);
    assign note_period = (state_q == ST_PLAY) ? period_q : '0;
    assign note_idx    = idx_q;
    // An abort during the DONE cycle suppresses the completion pulse
    assign done        = (state_q == ST_DONE) && !stop;

endmodule

`default_nettype wire

// File: tb/tb_music_note_sequencer.sv
// ============================================================================
//  Module      : tb_music_note_sequencer
//  Description : Randomized self-checking bench against a per-note trace model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_music_note_sequencer;

    localparam int TICK = 4;
    localparam int GAP  = 2;
    localparam int BIG  = 100000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [3:0] len = '0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_period = '0;
    logic [3:0] wr_dur = '0;
    logic [7:0] note_period;
    logic       note_valid;
    logic [2:0] note_idx;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;
    int cur_idx = 0;
    int tbl_p[8];
    int tbl_d[8];
    int exp_q[$];

    music_note_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .loop        (loop_en),
        .len         (len),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_period   (wr_period),
        .wr_dur      (wr_dur),
        .note_period (note_period),
        .note_valid  (note_valid),
        .note_idx    (note_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Packed view: busy, valid, done, idx, period
    function automatic int pk(int b, int v, int d, int idx, int p);
        return (b << 13) | (v << 12) | (d << 11) | ((idx & 7) << 8) | (p & 255);
    endfunction

    function automatic int obs();
        return pk(int'(busy), int'(note_valid), int'(done), int'(note_idx), int'(note_period));
    endfunction

    task automatic check_eq(string tag, int got, int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got b/v/d/idx/per=%h required %h", tag, got, exp);
        end
    endtask

    // Expected per-cycle trace of one playback, straight from the note rules
    function automatic void build(int len_v, bit lp, int cap);
        int n;
        int k;
        int cyc;
        exp_q.delete();
        n = (len_v > 8) ? 8 : len_v;
        if (n == 0) begin
            exp_q.push_back(pk(1, 0, 1, 0, 0));
            return;
        end
        k = 0;
        while (exp_q.size() < cap) begin
            cyc = ((tbl_d[k] == 0) ? 1 : tbl_d[k]) * TICK;
            repeat (cyc) exp_q.push_back(pk(1, int'(tbl_p[k] != 0), 0, k, tbl_p[k]));
            repeat (GAP) exp_q.push_back(pk(1, 0, 0, k, 0));
            if (k == n - 1) begin
                if (!lp) begin
                    exp_q.push_back(pk(1, 0, 1, k, 0));
                    break;
                end
                k = 0;
            end else begin
                k++;
            end
        end
    endfunction

    task automatic wr_entry(int a, int p, int d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 3'(a); wr_period = 8'(p); wr_dur = 4'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
        tbl_p[a] = p;
        tbl_d[a] = d;
    endtask

    task automatic run(string name, int len_v, bit lp, int stop_at, int wr_at, int wa, int wp, int wd);
        int e;
        @(posedge clk); #1;
        start = 1'b1; len = 4'(len_v); loop_en = lp; stop = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            start     = 1'($urandom % 2);
            len       = 4'($urandom_range(0, 15));
            stop      = (i == stop_at);
            wr_en     = (i == wr_at);
            wr_addr   = 3'(wa);
            wr_period = 8'(wp);
            wr_dur    = 4'(wd);
            @(negedge clk);
            e = exp_q[i];
            if (i == stop_at) e = e & ~(1 << 11);
            check_eq($sformatf("%s[%0d]", name, i), obs(), e);
            cur_idx = (e >> 8) & 7;
            if (i == stop_at) break;
        end
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check_eq({name, "_idle"}, obs(), pk(0, 0, 0, cur_idx, 0));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl_p[i] = 0;
            tbl_d[i] = 0;
        end
        #1 rst = 1'b0;
        #1 check_eq("reset_state", obs(), 0);
        #10 rst = 1'b1;

        // Reset mid-playback, then an all-zero table must read back as rests
        wr_entry(0, 10, 0);
        wr_entry(1, 20, 0);
        @(posedge clk); #1;
        start = 1'b1; len = 4'd2; loop_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 check_eq("pre_rst", obs(), pk(1, 1, 0, 1, 20));
        #1 rst = 1'b0;
        #1 check_eq("async_rst", obs(), 0);
        #2 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tbl_p[i] = 0;
            tbl_d[i] = 0;
        end
        cur_idx = 0;
        build(1, 0, BIG);
        run("cleared_tbl", 1, 0, -1, -1, 0, 0, 0);

        // One-shot, note then rest
        wr_entry(0, 10, 2);
        wr_entry(1, 0, 1);
        build(2, 0, BIG);
        run("oneshot2", 2, 0, -1, -1, 0, 0, 0);

        // Looping single note, aborted in the third PLAY pass
        wr_entry(0, 7, 1);
        build(1, 1, 14);
        run("loop_stop", 1, 1, 13, -1, 0, 0, 0);

        // Duration and length boundaries
        wr_entry(0, 5, 0);
        build(1, 0, BIG);
        run("dur0", 1, 0, -1, -1, 0, 0, 0);
        wr_entry(0, 9, 15);
        build(1, 0, BIG);
        run("dur15", 1, 0, -1, -1, 0, 0, 0);
        build(0, 0, BIG);
        run("len0", 0, 0, -1, -1, 0, 0, 0);
        for (int i = 0; i < 8; i++) wr_entry(i, $urandom_range(0, 255), $urandom_range(0, 3));
        build(15, 0, BIG);
        run("len15", 15, 0, -1, -1, 0, 0, 0);

        // start together with stop while idle
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b1; len = 4'd3;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        check_eq("start_stop_idle", obs(), pk(0, 0, 0, cur_idx, 0));

        // Write to entry 1 while entry 0 plays: new value is used
        wr_entry(0, 10, 1);
        wr_entry(1, 30, 2);
        tbl_p[1] = 44;
        tbl_d[1] = 3;
        build(2, 0, BIG);
        run("late_wr", 2, 0, -1, 1, 1, 44, 3);

        // Write on the very edge that loads entry 1: old value is used
        build(2, 0, BIG);
        run("same_cyc_wr", 2, 0, -1, 5, 1, 99, 7);
        tbl_p[1] = 99;
        tbl_d[1] = 7;
        build(2, 0, BIG);
        run("after_wr", 2, 0, -1, -1, 0, 0, 0);

        // Randomized one-shot and looping runs
        for (int r = 0; r < 24; r++) begin
            int lv;
            int sa;
            bit lp;
            for (int i = 0; i < 8; i++)
                wr_entry(i, ($urandom % 4 == 0) ? 0 : $urandom_range(1, 255), $urandom_range(0, 15));
            lp = 1'($urandom % 2);
            if (lp) begin
                lv = $urandom_range(1, 15);
                sa = $urandom_range(0, 150);
                build(lv, 1, sa + 1);
            end else begin
                lv = $urandom_range(0, 15);
                build(lv, 0, BIG);
                sa = ($urandom % 3 == 0) ? $urandom_range(0, exp_q.size() - 1) : -1;
            end
            run($sformatf("rnd%0d", r), lv, lp, sa, -1, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
